// File: rtl/gcd_engine.sv
// gcd_engine: parametrised GCD unit with integrated datapath and controller.
// A start pulse in IDLE loads the operands; the engine then performs one
// reduction step per clock (subtractive Euclid or binary Stein, chosen by
// ALGO) until a terminating condition is met, pulses done for one cycle and
// returns to IDLE. result, zero_err and iter_count are held until the next
// accepted start.
module gcd_engine #(
  parameter int WIDTH = 16,
  parameter int ALGO  = 0,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_err,
  output logic [CNT_W-1:0] iter_count
);

  // k counts the common factors of two removed by the binary algorithm. It can
  // never exceed WIDTH-1, so clog2(WIDTH)+1 bits always suffice.
  localparam int K_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [K_W-1:0]   k;

  // Operand classification shared by the termination and step logic.
  logic             a_zero;
  logic             b_zero;
  logic             a_even;
  logic             b_even;
  logic             a_eq_b;
  logic             a_gt_b;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] diff_ba;

  // Result of evaluating one CALC step on the current operands.
  logic             term;
  logic             term_zero;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;
  logic [K_W-1:0]   next_k;

  // Saturating increment of the step counter.
  logic             iter_full;
  logic [CNT_W-1:0] iter_next;

  // Compare and difference terms; only the larger-minus-smaller difference is
  // ever used, so neither subtraction can underflow when it matters.
  always_comb begin
    a_zero  = (reg_a == '0);
    b_zero  = (reg_b == '0);
    a_even  = ~reg_a[0];
    b_even  = ~reg_b[0];
    a_eq_b  = (reg_a == reg_b);
    a_gt_b  = (reg_a > reg_b);
    diff_ab = reg_a - reg_b;
    diff_ba = reg_b - reg_a;
  end

  // One reduction step: termination checks in priority order, otherwise the
  // algorithm-specific update of A, B and k.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    term      = 1'b0;
    term_zero = 1'b0;
    term_val  = '0;
    next_a    = reg_a;
    next_b    = reg_b;
    next_k    = k;

    if (a_zero && b_zero) begin
      term      = 1'b1;
      term_zero = 1'b1;
    end else if (a_zero) begin
      term     = 1'b1;
      term_val = reg_b << k;
    end else if (b_zero) begin
      term     = 1'b1;
      term_val = reg_a << k;
    end else if (a_eq_b) begin
      term     = 1'b1;
      term_val = reg_a << k;
    end else if (ALGO == 0) begin
      // Subtractive Euclid: reduce the larger operand by the smaller one.
      if (a_gt_b) begin
        next_a = diff_ab;
      end else begin
        next_b = diff_ba;
      end
    end else begin
      // Binary Stein: strip factors of two, then subtract between odd values.
      if (a_even && b_even) begin
        next_a = reg_a >> 1;
        next_b = reg_b >> 1;
        next_k = k + K_W'(1);
      end else if (a_even) begin
        next_a = reg_a >> 1;
      end else if (b_even) begin
        next_b = reg_b >> 1;
      end else if (a_gt_b) begin
        next_a = diff_ab;
      end else begin
        next_b = diff_ba;
      end
    end
  end

  // Step counter increments on every CALC step and sticks at all-ones.
  always_comb begin
    iter_full = &iter_count;
    iter_next = iter_full ? iter_count : iter_count + CNT_W'(1);
  end

  // Controller and datapath registers: IDLE -> CALC -> DONE -> IDLE, with all
  // outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      reg_a      <= '0;
      reg_b      <= '0;
      k          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      zero_err   <= 1'b0;
      iter_count <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // in this block samples the pre-edge values, matching real flip-flops.
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            reg_a      <= a_in;
            reg_b      <= b_in;
            k          <= '0;
            iter_count <= '0;
            zero_err   <= 1'b0;
            busy       <= 1'b1;
            state      <= S_CALC;
          end
        end

        S_CALC: begin
          iter_count <= iter_next;
          if (term) begin
            result   <= term_val;
            zero_err <= term_zero;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            reg_a <= next_a;
            reg_b <= next_b;
            k     <= next_k;
          end
        end

        S_DONE: begin
          // start is deliberately ignored here; a new request is only taken
          // once the engine is back in IDLE.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed and randomised checks of gcd_engine against a
// behavioural gcd model. Four instances: WIDTH=8 Euclid, WIDTH=8 Stein,
// WIDTH=16 Euclid, WIDTH=16 Stein.
module tb_gcd_engine;

  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_v;
  logic [15:0] a_v [4];
  logic [15:0] b_v [4];
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  zerr_v;
  logic [15:0] res_v [4];
  logic [16:0] iter_v [4];

  logic [7:0]  r0, r1;
  logic [8:0]  i0, i1;
  logic [15:0] r2, r3;
  logic [16:0] i2, i3;

  int checks   = 0;
  int failures = 0;

  logic [15:0] got_res   [4];
  logic        got_zerr  [4];
  logic [16:0] got_iter  [4];
  int          got_busy  [4];
  int          got_dones [4];
  logic        timed_out;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(8), .ALGO(0)) u_w8_euclid (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_in(a_v[0][7:0]), .b_in(b_v[0][7:0]),
    .busy(busy_v[0]), .done(done_v[0]), .result(r0), .zero_err(zerr_v[0]), .iter_count(i0));
  gcd_engine #(.WIDTH(8), .ALGO(1)) u_w8_stein (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_in(a_v[1][7:0]), .b_in(b_v[1][7:0]),
    .busy(busy_v[1]), .done(done_v[1]), .result(r1), .zero_err(zerr_v[1]), .iter_count(i1));
  gcd_engine #(.WIDTH(16), .ALGO(0)) u_w16_euclid (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a_in(a_v[2]), .b_in(b_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .result(r2), .zero_err(zerr_v[2]), .iter_count(i2));
  gcd_engine #(.WIDTH(16), .ALGO(1)) u_w16_stein (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a_in(a_v[3]), .b_in(b_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .result(r3), .zero_err(zerr_v[3]), .iter_count(i3));

  assign res_v[0]  = {8'h00, r0};
  assign res_v[1]  = {8'h00, r1};
  assign res_v[2]  = r2;
  assign res_v[3]  = r3;
  assign iter_v[0] = {8'h00, i0};
  assign iter_v[1] = {8'h00, i1};
  assign iter_v[2] = i2;
  assign iter_v[3] = i3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference gcd by the remainder form of Euclid's algorithm.
  function automatic logic [15:0] ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[15:0];
  endfunction

  // Subtractive step count: one step if either operand is zero, otherwise the
  // sum of the Euclid quotients (subtractions until equal, plus the final step).
  function automatic int ref_euclid_steps(input int x, input int y);
    int s;
    int t;
    if (x == 0 || y == 0) return 1;
    s = 0;
    while (y != 0) begin
      s += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    return s;
  endfunction

  // Launch one operation on every instance in mask and collect its outputs.
  task automatic run(input logic [3:0] mask, input logic [15:0] a, input logic [15:0] b);
    logic [3:0] seen;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        a_v[i] = a;
        b_v[i] = b;
        got_busy[i]  = 0;
        got_dones[i] = 0;
      end
    end
    start_v = mask;
    @(negedge clk);
    start_v = '0;
    seen = '0;
    for (int c = 0; c < BUDGET; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          if (busy_v[i]) got_busy[i]++;
          if (done_v[i]) begin
            got_dones[i]++;
            if (!seen[i]) begin
              got_res[i]  = res_v[i];
              got_zerr[i] = zerr_v[i];
              got_iter[i] = iter_v[i];
            end
            seen[i] = 1'b1;
          end
        end
      end
      if ((seen & mask) == mask) break;
      @(negedge clk);
    end
    timed_out = ((seen & mask) != mask);
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          if (busy_v[i]) got_busy[i]++;
          if (done_v[i]) got_dones[i]++;
        end
      end
    end
  endtask

  task automatic expect_op(input int i, input string tag, input logic [15:0] res,
                           input logic zerr, input int iter);
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check({tag, "_result"}, 32'(got_res[i]), 32'(res));
    check({tag, "_zero_err"}, 32'(got_zerr[i]), 32'(zerr));
    if (iter >= 0) check({tag, "_iter"}, 32'(got_iter[i]), 32'(iter));
    check({tag, "_done_pulses"}, 32'(got_dones[i]), 32'd1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dcount;
    logic        seen_done;
    logic [15:0] ra;
    logic [15:0] rb;
    int          g;
    int          p;
    int          q;
    int          steps;
    logic [15:0] exp_g;

    start_v = '0;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_busy%0d", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("reset_done%0d", i), 32'(done_v[i]), 32'd0);
      check($sformatf("reset_result%0d", i), 32'(res_v[i]), 32'd0);
      check($sformatf("reset_zero_err%0d", i), 32'(zerr_v[i]), 32'd0);
      check($sformatf("reset_iter%0d", i), 32'(iter_v[i]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic operation, both algorithms, 8-bit.
    run(4'b0001, 16'd48, 16'd18);
    expect_op(0, "euclid_48_18", 16'd6, 1'b0, 5);
    check("euclid_48_18_busy_cycles", 32'(got_busy[0]), 32'd6);
    run(4'b0010, 16'd48, 16'd18);
    expect_op(1, "stein_48_18", 16'd6, 1'b0, 7);
    run(4'b0001, 16'd255, 16'd1);
    expect_op(0, "euclid_255_1", 16'd1, 1'b0, 255);
    check("euclid_255_1_busy_cycles", 32'(got_busy[0]), 32'd256);

    // Zero operands on both 8-bit instances.
    run(4'b0011, 16'd0, 16'd0);
    expect_op(0, "euclid_0_0", 16'd0, 1'b1, 1);
    expect_op(1, "stein_0_0", 16'd0, 1'b1, 1);
    run(4'b0011, 16'd0, 16'd35);
    expect_op(0, "euclid_0_35", 16'd35, 1'b0, 1);
    expect_op(1, "stein_0_35", 16'd35, 1'b0, 1);
    run(4'b0011, 16'd35, 16'd0);
    expect_op(0, "euclid_35_0", 16'd35, 1'b0, 1);
    expect_op(1, "stein_35_0", 16'd35, 1'b0, 1);

    // start held high through CALC with changing operands, then back-to-back.
    @(negedge clk);
    a_v[0] = 16'd48;
    b_v[0] = 16'd18;
    start_v[0] = 1'b1;
    seen_done = 1'b0;
    dcount = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_v[0]) begin
        seen_done = 1'b1;
        break;
      end
      a_v[0] = 16'($urandom);
      b_v[0] = 16'($urandom);
    end
    check("held_start_done_seen", 32'(seen_done), 32'd1);
    check("held_start_result", 32'(res_v[0]), 32'd6);
    check("held_start_iter", 32'(iter_v[0]), 32'd5);
    a_v[0] = 16'd20;
    b_v[0] = 16'd8;
    @(negedge clk);
    check("idle_after_done_busy", 32'(busy_v[0]), 32'd0);
    check("idle_after_done_done", 32'(done_v[0]), 32'd0);
    @(negedge clk);
    start_v[0] = 1'b0;
    check("b2b_accepted_busy", 32'(busy_v[0]), 32'd1);
    check("b2b_result_held", 32'(res_v[0]), 32'd6);
    seen_done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done_v[0]) begin
        dcount++;
        if (!seen_done) begin
          check("b2b_result", 32'(res_v[0]), 32'd4);
          check("b2b_iter", 32'(iter_v[0]), 32'd4);
        end
        seen_done = 1'b1;
      end
      @(negedge clk);
    end
    check("b2b_done_pulses", 32'(dcount), 32'd1);
    check("b2b_result_after_idle", 32'(res_v[0]), 32'd4);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    a_v[0] = 16'd255;
    b_v[0] = 16'd1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_busy", 32'(busy_v[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy_v[0]), 32'd0);
    check("midreset_done", 32'(done_v[0]), 32'd0);
    check("midreset_result", 32'(res_v[0]), 32'd0);
    check("midreset_iter", 32'(iter_v[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_v[0]) dcount++;
    end
    check("midreset_no_done", 32'(dcount), 32'd0);
    run(4'b0001, 16'd48, 16'd18);
    expect_op(0, "post_reset_48_18", 16'd6, 1'b0, 5);

    // Randomised 16-bit operands, both algorithms run on the same pair.
    for (int n = 0; n < 1000; n++) begin
      g = int'($urandom_range(1, 255));
      p = int'($urandom_range(0, 255));
      q = int'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) p = 0;
      if ($urandom_range(0, 31) == 0) q = 0;
      ra = 16'(g * p);
      rb = 16'(g * q);
      exp_g = ref_gcd(int'(ra), int'(rb));
      steps = ref_euclid_steps(int'(ra), int'(rb));
      run(4'b1100, ra, rb);
      expect_op(2, $sformatf("rand_euclid_%0d_%0d", ra, rb), exp_g,
                (ra == 16'd0) && (rb == 16'd0), steps);
      check($sformatf("rand_euclid_busy_%0d_%0d", ra, rb), 32'(got_busy[2]), 32'(steps + 1));
      expect_op(3, $sformatf("rand_stein_%0d_%0d", ra, rb), exp_g,
                (ra == 16'd0) && (rb == 16'd0), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
